// File: rtl/decoder_scan_ctrl_if.sv
// Sequencer-to-decoder bundle: sweep controls in, decoder select/enable and status out.
// The sequencer uses the slave modport; whoever commands the sweep uses master.
interface decoder_scan_ctrl_if;
  logic       run;
  logic [7:0] ch_mask;
  logic [2:0] sel;
  logic       ena;
  logic       frame_done;
  logic       busy;

  modport master (
    output run, ch_mask,
    input  sel, ena, frame_done, busy
  );

  modport slave (
    input  run, ch_mask,
    output sel, ena, frame_done, busy
  );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Sweeps the active channels of a decoder3to8 in ascending order with a blank gap before
// each dwell, so sel never changes while ena is high.
module decoder_scan_ctrl #(
  parameter int unsigned DWELL_CYC = 1000,
  parameter int unsigned BLANK_CYC = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  decoder_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DWELL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       sel_q;
  logic             ena_q;
  logic             done_q;
  logic             busy_q;

  logic [7:0]       above;
  logic [2:0]       first_sel;
  logic [2:0]       next_sel;
  logic             last_ch;
  logic             mask_any;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_set = 3'(i);
    end
  endfunction

  // Channels strictly above the current sel; none left means this dwell closes the sweep.
  always_comb begin
    mask_any  = |bus.ch_mask;
    above     = bus.ch_mask & ~((8'd2 << sel_q) - 8'd1);
    first_sel = lowest_set(bus.ch_mask);
    last_ch   = (above == 8'd0);
    next_sel  = last_ch ? first_sel : lowest_set(above);
  end

  // NOTE: every register here uses <= so all branches see pre-edge values of state/cnt/sel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      sel_q  <= 3'd0;
      ena_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.run && mask_any) begin
            state  <= BLANK;
            sel_q  <= first_sel;
            cnt    <= BLANK_LOAD;
            busy_q <= 1'b1;
          end
        end

        BLANK: begin
          if (cnt == '0) begin
            state <= DWELL;
            ena_q <= 1'b1;
            cnt   <= DWELL_LOAD;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        DWELL: begin
          if (cnt == '0) begin
            ena_q  <= 1'b0;
            done_q <= last_ch && mask_any;
            if (bus.run && mask_any) begin
              state <= BLANK;
              sel_q <= next_sel;
              cnt   <= BLANK_LOAD;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: begin
          state  <= IDLE;
          ena_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel        = sel_q;
  assign bus.ena        = ena_q;
  assign bus.frame_done = done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl with DWELL_CYC=4, BLANK_CYC=2 (channel period 6).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_decoder_scan_ctrl;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  decoder_scan_ctrl_if bus ();

  decoder_scan_ctrl #(
    .DWELL_CYC (4),
    .BLANK_CYC (2),
    .CNT_W     (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] sel, input logic ena,
                            input logic fd, input logic busy);
    check({tag, " sel"},        8'(bus.sel),        8'(sel));
    check({tag, " ena"},        8'(bus.ena),        8'(ena));
    check({tag, " frame_done"}, 8'(bus.frame_done), 8'(fd));
    check({tag, " busy"},       8'(bus.busy),       8'(busy));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] chans3 [3];
    chans3[0] = 3'd2;
    chans3[1] = 3'd5;
    chans3[2] = 3'd7;

    bus.run     = 1'b0;
    bus.ch_mask = 8'h00;

    // Reset with the clock stopped: outputs must clear with no edge.
    #3 rst_n = 1'b0;
    #1 check_outs("reset_noclk", 3'd0, 1'b0, 1'b0, 1'b0);
    #10 clk_en = 1'b1;
    tick();
    rst_n = 1'b1;

    // Empty mask with run=1 stays idle.
    bus.run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_outs($sformatf("empty_mask%0d", k), 3'd0, 1'b0, 1'b0, 1'b0);
    end

    // Full sweep: sel 0..7, ena 0,0,1,1,1,1 per channel, frame_done after ch 7.
    // run drops on the 2nd dwell cycle of ch 3 in the second sweep (sample 69).
    bus.ch_mask = 8'hFF;
    for (int k = 0; k < 72; k++) begin
      tick();
      check_outs($sformatf("sweep_ff%0d", k), 3'((k / 6) % 8), (k % 6) >= 2,
                 (k > 0) && (k % 48 == 0), 1'b1);
      if (k == 69) bus.run = 1'b0;
    end
    tick();
    check_outs("stop_ch3", 3'd3, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("stop_ch3_idle", 3'd3, 1'b0, 1'b0, 1'b0);

    // Sparse mask 1010_0100: sel 2,5,7,2; frame_done only after ch 7; stop on ch 2 (no pulse).
    bus.ch_mask = 8'b1010_0100;
    bus.run     = 1'b1;
    for (int k = 0; k < 24; k++) begin
      tick();
      check_outs($sformatf("sweep_a4_%0d", k), chans3[(k / 6) % 3], (k % 6) >= 2,
                 k == 18, 1'b1);
      if (k == 23) bus.run = 1'b0;
    end
    tick();
    check_outs("stop_ch2", 3'd2, 1'b0, 1'b0, 1'b0);

    // Single channel 4: same sel each period, frame_done after every dwell,
    // including the final one when stopping.
    bus.ch_mask = 8'h10;
    bus.run     = 1'b1;
    for (int k = 0; k < 18; k++) begin
      tick();
      check_outs($sformatf("single%0d", k), 3'd4, (k % 6) >= 2,
                 (k > 0) && (k % 6 == 0), 1'b1);
      if (k == 17) bus.run = 1'b0;
    end
    tick();
    check_outs("stop_single", 3'd4, 1'b0, 1'b1, 1'b0);
    tick();
    check_outs("idle_hold_sel", 3'd4, 1'b0, 1'b0, 1'b0);

    // Reset mid-dwell of ch 5, then restart from ch 0.
    bus.ch_mask = 8'hFF;
    bus.run     = 1'b1;
    for (int k = 0; k < 34; k++) begin
      tick();
      check_outs($sformatf("pre_reset%0d", k), 3'((k / 6) % 8), (k % 6) >= 2, 1'b0, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1 check_outs("reset_middwell", 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_outs($sformatf("restart%0d", k), 3'((k / 6) % 8), (k % 6) >= 2, 1'b0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
